writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-back end of the register-file interface; drives the single GPR/FPR write port of the decode stage (regwrite / dtowrite / regdst).
- Collects completed results from three producers (load unit, FPU, integer ALU) that may finish in the same cycle.
- Serialises them through a small multi-push FIFO, one register write per cycle.
- Exports back-pressure and pending-destination masks for hazard detection.

Parameters:
- DEPTH, 4, number of FIFO entries, ≥3.
- CNT_W, 3, width of the occupancy counter; must hold 0..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- ld_valid, fp_valid, al_valid  in  1 each  result valid from load / FPU / ALU.
- ld_rw, fp_rw, al_rw  in  2 each  target file: 01 = GPR, 10 = FPR, 00 or 11 = no write.
- ld_dst, fp_dst, al_dst  in  5 each  destination register index.
- ld_data, fp_data, al_data  in  32 each  result value.
- regwrite  out  2  write enable/file select to decode (01 GPR, 10 FPR, 00 idle).
- regdst  out  5  register index written.
- dtowrite  out  32  data written.
- stall  out  1  producers must not present results next cycle.
- overflow  out  1  sticky: a result was dropped for lack of space.
- pend_gpr  out  32  bit i set if a GPR write to i is queued or on the output.
- pend_fpr  out  32  bit i set if an FPR write to i is queued or on the output.

Behaviour:
- Reset (async, rstn = 0): FIFO empty, count = 0, regwrite = 00, regdst = 0, dtowrite = 0, overflow = 0, stall = 0, pend masks = 0. Reset takes effect immediately, mid-burst included, and queued results are discarded.
- Candidate filter: an input is a candidate only if valid = 1 and rw ∈ {01, 10}. rw = 01 with dst = 0 is discarded (GPR r0 is never written). FPR f0 is written normally.
- Order within a cycle: load, then FPU, then ALU. Each candidate is appended behind the existing FIFO contents in that order.
- Each rising edge:
  - The output register loads the head of the combined sequence (existing FIFO entries followed by this cycle's candidates).
  - If that sequence is empty, regwrite = 00; regdst and dtowrite hold their previous values.
  - The remaining entries stay or are appended, preserving order.
- Latency: a lone result into an empty arbiter appears on regwrite/regdst/dtowrite the next cycle, as a 1-cycle bypass.
- Throughput: exactly one write per cycle while entries exist. The output holds each write for one cycle only.
- Occupancy: count_next = count + accepted − (count + accepted > 0 ? 1 : 0). Invariant: count ≤ DEPTH.
- Space limit: accepted candidates ≤ DEPTH − count + 1. Candidates beyond the limit are dropped lowest priority first (ALU, then FPU, then load), and overflow is set until reset.
- stall = ((DEPTH − count) < 3), combinational from registered count. Producers honouring stall never cause overflow.
- pend masks: the OR over valid FIFO entries plus the current output register (when regwrite ≠ 00), decoded by file. Derived from registered state only; this cycle's inputs are not included.
- Duplicate destinations are allowed. Writes retire in order, so the last one wins in the register file. A pend bit clears only when no entry targets that register.

Test Plan:
- Single result: after reset, al_valid = 1, al_rw = 01, al_dst = 5, al_data = 0x0000002A for one cycle.
  → Next cycle regwrite = 01, regdst = 5, dtowrite = 0x2A, pend_gpr[5] = 1.
  → Following cycle regwrite = 00, pend_gpr = 0.
- Triple collision: ld (01, r3, 0x11), fp (10, f7, 0x3F800000), al (01, r4, 0x22) in the same cycle.
  → Outputs on 3 consecutive cycles in order r3 / f7 / r4.
  → stall = 1 the cycle after the collision (count = 2), then 0.
- Filtering: al_valid = 1 with rw = 01, dst = 0; fp_valid = 1 with rw = 00.
  → No write and no pend bit set.
  → fp rw = 10, dst = 0, data = 0x40000000 → FPR write to f0 occurs.
- Overflow: ignore stall and present 3 GPR results (r1, r2, r3) each cycle for 3 cycles with DEPTH = 4.
  → The third cycle's ALU result (r3) is dropped, and the FPU result too if space is exhausted.
  → overflow = 1 stays set. Accepted results retire strictly in order.
- Reset mid-operation: queue 3 entries, assert rstn = 0 between clock edges.
  → Outputs go to reset values immediately, without waiting for an edge.
  → After release no queued write emerges and overflow = 0.
- Duplicate destination: ld (01, r9, 0x1) then al (01, r9, 0x2) in the same cycle.
  → Writes 0x1 then 0x2 to r9.
  → pend_gpr[9] = 1 for 2 cycles, then 0.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Producer/write-back bundle for writeback_arbiter: three result ports in,
// register-file write port and hazard status out.
interface writeback_arbiter_if;
   logic        ld_valid, fp_valid, al_valid;
   logic [1:0]  ld_rw, fp_rw, al_rw;
   logic [4:0]  ld_dst, fp_dst, al_dst;
   logic [31:0] ld_data, fp_data, al_data;
   logic [1:0]  regwrite;
   logic [4:0]  regdst;
   logic [31:0] dtowrite;
   logic        stall;
   logic        overflow;
   logic [31:0] pend_gpr;
   logic [31:0] pend_fpr;

   modport master (
      output ld_valid, fp_valid, al_valid,
      output ld_rw, fp_rw, al_rw,
      output ld_dst, fp_dst, al_dst,
      output ld_data, fp_data, al_data,
      input  regwrite, regdst, dtowrite, stall, overflow, pend_gpr, pend_fpr
   );

   modport slave (
      input  ld_valid, fp_valid, al_valid,
      input  ld_rw, fp_rw, al_rw,
      input  ld_dst, fp_dst, al_dst,
      input  ld_data, fp_data, al_data,
      output regwrite, regdst, dtowrite, stall, overflow, pend_gpr, pend_fpr
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Serialises load/FPU/ALU results through a multi-push FIFO onto the single
// register-file write port, one write per cycle, with pending-destination masks.
module writeback_arbiter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic               clk,
   input  logic               rstn,
   writeback_arbiter_if.slave bus
);

   typedef struct packed {
      logic        fpr;
      logic [4:0]  dst;
      logic [31:0] data;
   } entry_t;

   localparam int unsigned SEQ = DEPTH + 3;

   entry_t            fifo_q [DEPTH];
   entry_t            fifo_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        regwrite_q, regwrite_d;
   logic [4:0]        regdst_q, regdst_d;
   logic [31:0]       dtowrite_q, dtowrite_d;
   logic              overflow_q, overflow_d;

   logic   [2:0] cand_v;
   entry_t       cand_e [3];
   entry_t       seq    [SEQ];
   int unsigned  cnt, n, acc;

   // Candidate filter in priority order: load, FPU, ALU. GPR r0 is never written.
   always_comb begin
      cand_v[0] = bus.ld_valid && ((bus.ld_rw == 2'b01 && bus.ld_dst != 5'd0) || bus.ld_rw == 2'b10);
      cand_v[1] = bus.fp_valid && ((bus.fp_rw == 2'b01 && bus.fp_dst != 5'd0) || bus.fp_rw == 2'b10);
      cand_v[2] = bus.al_valid && ((bus.al_rw == 2'b01 && bus.al_dst != 5'd0) || bus.al_rw == 2'b10);
      cand_e[0] = '{fpr: bus.ld_rw[1], dst: bus.ld_dst, data: bus.ld_data};
      cand_e[1] = '{fpr: bus.fp_rw[1], dst: bus.fp_dst, data: bus.fp_data};
      cand_e[2] = '{fpr: bus.al_rw[1], dst: bus.al_dst, data: bus.al_data};
   end

   // Combined sequence = queued entries then accepted candidates; head goes to
   // the output register and the tail becomes the new FIFO contents.
   always_comb begin
      cnt        = 32'(count_q);
      n          = cnt;
      acc        = 0;
      overflow_d = overflow_q;
      for (int unsigned p = 0; p < SEQ; p++) seq[p] = '0;
      for (int unsigned k = 0; k < DEPTH; k++)
         if (k < cnt) seq[k] = fifo_q[k];
      for (int unsigned i = 0; i < 3; i++) begin
         if (cand_v[i]) begin
            if (acc < 32'(DEPTH) - cnt + 1) begin
               for (int unsigned p = 0; p < SEQ; p++)
                  if (p == n) seq[p] = cand_e[i];
               n   = n + 1;
               acc = acc + 1;
            end else begin
               overflow_d = 1'b1;
            end
         end
      end

      for (int unsigned k = 0; k < DEPTH; k++) fifo_d[k] = seq[k + 1];
      regdst_d   = regdst_q;
      dtowrite_d = dtowrite_q;
      if (n > 0) begin
         regwrite_d = seq[0].fpr ? 2'b10 : 2'b01;
         regdst_d   = seq[0].dst;
         dtowrite_d = seq[0].data;
         count_d    = CNT_W'(n - 1);
      end else begin
         regwrite_d = 2'b00;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < DEPTH; k++) fifo_q[k] <= '0;
         count_q    <= '0;
         regwrite_q <= '0;
         regdst_q   <= '0;
         dtowrite_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) fifo_q[k] <= fifo_d[k];
         count_q    <= count_d;
         regwrite_q <= regwrite_d;
         regdst_q   <= regdst_d;
         dtowrite_q <= dtowrite_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      bus.pend_gpr = '0;
      bus.pend_fpr = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (k < cnt) begin
            if (fifo_q[k].fpr) bus.pend_fpr[fifo_q[k].dst] = 1'b1;
            else               bus.pend_gpr[fifo_q[k].dst] = 1'b1;
         end
      end
      if (regwrite_q == 2'b01) bus.pend_gpr[regdst_q] = 1'b1;
      if (regwrite_q == 2'b10) bus.pend_fpr[regdst_q] = 1'b1;
   end

   assign bus.stall    = (32'(DEPTH) - cnt) < 32'd3;
   assign bus.regwrite = regwrite_q;
   assign bus.regdst   = regdst_q;
   assign bus.dtowrite = dtowrite_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: each step drives producers, clocks once
// and checks the write port, stall, overflow and pend masks against constants.
module tb_writeback_arbiter;
   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   writeback_arbiter_if bus ();

   writeback_arbiter #(.DEPTH(4), .CNT_W(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.ld_valid = 0; bus.fp_valid = 0; bus.al_valid = 0;
      bus.ld_rw = 0; bus.fp_rw = 0; bus.al_rw = 0;
      bus.ld_dst = 0; bus.fp_dst = 0; bus.al_dst = 0;
      bus.ld_data = 0; bus.fp_data = 0; bus.al_data = 0;
   endtask

   task automatic drive(input int unit, input logic [1:0] rw, input logic [4:0] dst,
                        input logic [31:0] data);
      case (unit)
         0: begin bus.ld_valid = 1; bus.ld_rw = rw; bus.ld_dst = dst; bus.ld_data = data; end
         1: begin bus.fp_valid = 1; bus.fp_rw = rw; bus.fp_dst = dst; bus.fp_data = data; end
         default: begin bus.al_valid = 1; bus.al_rw = rw; bus.al_dst = dst; bus.al_data = data; end
      endcase
   endtask

   // Clock once; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_wr(input string tag, input logic [1:0] rw, input logic [4:0] dst,
                         input logic [31:0] data);
      chk({tag, ".rw"},   32'(bus.regwrite), 32'(rw));
      chk({tag, ".dst"},  32'(bus.regdst),   32'(dst));
      chk({tag, ".data"}, bus.dtowrite,      data);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_inputs();
      rstn = 1'b0;
      #12;
      chk("rst.rw", 32'(bus.regwrite), 0);
      chk("rst.dst", 32'(bus.regdst), 0);
      chk("rst.data", bus.dtowrite, 0);
      chk("rst.stall", 32'(bus.stall), 0);
      chk("rst.ovf", 32'(bus.overflow), 0);
      chk("rst.pg", bus.pend_gpr, 0);
      chk("rst.pf", bus.pend_fpr, 0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // Single result with one-cycle bypass
      drive(2, 2'b01, 5'd5, 32'h2A);
      tick(); clear_inputs();
      chk_wr("single", 2'b01, 5'd5, 32'h2A);
      chk("single.pg", bus.pend_gpr, 32'h20);
      tick();
      chk_wr("single.idle", 2'b00, 5'd5, 32'h2A);
      chk("single.idle.pg", bus.pend_gpr, 0);

      // Triple collision retires load, FPU, ALU in order
      drive(0, 2'b01, 5'd3, 32'h11);
      drive(1, 2'b10, 5'd7, 32'h3F800000);
      drive(2, 2'b01, 5'd4, 32'h22);
      tick(); clear_inputs();
      chk_wr("tri0", 2'b01, 5'd3, 32'h11);
      chk("tri0.stall", 32'(bus.stall), 1);
      chk("tri0.pg", bus.pend_gpr, 32'h18);
      chk("tri0.pf", bus.pend_fpr, 32'h80);
      tick();
      chk_wr("tri1", 2'b10, 5'd7, 32'h3F800000);
      chk("tri1.stall", 32'(bus.stall), 0);
      tick();
      chk_wr("tri2", 2'b01, 5'd4, 32'h22);
      tick();
      chk("tri.idle", 32'(bus.regwrite), 0);

      // Filtering: r0 GPR and rw=00 discarded; f0 written
      drive(2, 2'b01, 5'd0, 32'h55);
      drive(1, 2'b00, 5'd6, 32'h66);
      tick(); clear_inputs();
      chk("filt.rw", 32'(bus.regwrite), 0);
      chk("filt.pg", bus.pend_gpr, 0);
      chk("filt.pf", bus.pend_fpr, 0);
      drive(1, 2'b10, 5'd0, 32'h40000000);
      tick(); clear_inputs();
      chk_wr("f0", 2'b10, 5'd0, 32'h40000000);
      chk("f0.pf", bus.pend_fpr, 32'h1);
      tick();
      chk("f0.idle", 32'(bus.regwrite), 0);

      // Overflow: three GPR results per cycle for three cycles, stall ignored
      for (int c = 1; c <= 3; c++) begin
         drive(0, 2'b01, 5'd1, 32'(c * 16 + 1));
         drive(1, 2'b01, 5'd2, 32'(c * 16 + 2));
         drive(2, 2'b01, 5'd3, 32'(c * 16 + 3));
         tick();
         case (c)
            1: begin
               chk_wr("ovf.c1", 2'b01, 5'd1, 32'h11);
               chk("ovf.c1.ovf", 32'(bus.overflow), 0);
               chk("ovf.c1.stall", 32'(bus.stall), 1);
            end
            2: begin
               chk_wr("ovf.c2", 2'b01, 5'd2, 32'h12);
               chk("ovf.c2.ovf", 32'(bus.overflow), 0);
            end
            default: begin
               chk_wr("ovf.c3", 2'b01, 5'd3, 32'h13);
               chk("ovf.c3.ovf", 32'(bus.overflow), 1);
               chk("ovf.c3.pg", bus.pend_gpr, 32'hE);
            end
         endcase
      end
      clear_inputs();
      tick(); chk_wr("ovf.r0", 2'b01, 5'd1, 32'h21);
      tick(); chk_wr("ovf.r1", 2'b01, 5'd2, 32'h22);
      tick(); chk_wr("ovf.r2", 2'b01, 5'd3, 32'h23);
      tick(); chk_wr("ovf.r3", 2'b01, 5'd1, 32'h31);
      chk("ovf.r3.stall", 32'(bus.stall), 0);
      tick();
      chk("ovf.idle", 32'(bus.regwrite), 0);
      chk("ovf.sticky", 32'(bus.overflow), 1);
      chk("ovf.idle.pg", bus.pend_gpr, 0);

      // Asynchronous reset between edges discards queued results
      drive(0, 2'b01, 5'd3, 32'h11);
      drive(1, 2'b10, 5'd7, 32'h3F800000);
      drive(2, 2'b01, 5'd4, 32'h22);
      tick(); clear_inputs();
      chk("mid.pre", 32'(bus.regwrite), 1);
      #1 rstn = 1'b0;
      #1;
      chk("mid.rw", 32'(bus.regwrite), 0);
      chk("mid.dst", 32'(bus.regdst), 0);
      chk("mid.data", bus.dtowrite, 0);
      chk("mid.ovf", 32'(bus.overflow), 0);
      chk("mid.stall", 32'(bus.stall), 0);
      chk("mid.pg", bus.pend_gpr, 0);
      chk("mid.pf", bus.pend_fpr, 0);
      #1 rstn = 1'b1;
      tick(); chk("mid.post0", 32'(bus.regwrite), 0);
      tick(); chk("mid.post1", 32'(bus.regwrite), 0);
      chk("mid.post.ovf", 32'(bus.overflow), 0);

      // Duplicate destination: both writes retire in order
      drive(0, 2'b01, 5'd9, 32'h1);
      drive(2, 2'b01, 5'd9, 32'h2);
      tick(); clear_inputs();
      chk_wr("dup0", 2'b01, 5'd9, 32'h1);
      chk("dup0.pg", bus.pend_gpr, 32'h200);
      tick();
      chk_wr("dup1", 2'b01, 5'd9, 32'h2);
      chk("dup1.pg", bus.pend_gpr, 32'h200);
      tick();
      chk("dup.idle", 32'(bus.regwrite), 0);
      chk("dup.idle.pg", bus.pend_gpr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
